// File: rtl/otp_pkg.sv
// Shared constants for the OTP session sequencer: field widths, FSM state codes and a width helper.
package otp_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned OTP_W   = 16;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ENTRY   = 3'd1;
    localparam logic [2:0] ST_CHECK   = 3'd2;
    localparam logic [2:0] ST_GRANT   = 3'd3;
    localparam logic [2:0] ST_EXPIRED = 3'd4;
    localparam logic [2:0] ST_LOCKOUT = 3'd5;

    // Bits needed to hold values 0..max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/otp_cycle_timer.sv
// Loadable down-counter shared by the expiry, unlock-hold and lockout phases.
module otp_cycle_timer #(
    parameter int unsigned WIDTH = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    // Holds at zero once expired so an idle phase never wraps around.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/otp_session_ctrl.sv
// Session sequencer: OTP capture, digit collection, compare, and expiry/unlock/lockout timing.
module otp_session_ctrl
    import otp_pkg::*;
#(
    parameter int unsigned DIGITS        = 4,
    parameter int unsigned EXPIRE_CYCLES = 1000,
    parameter int unsigned UNLOCK_HOLD   = 50,
    parameter int unsigned LOCK_CYCLES   = 2000,
    parameter int unsigned MAX_ATTEMPTS  = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               gen_req,
    input  logic [OTP_W-1:0]   lfsr_word,
    input  logic [DIGIT_W-1:0] digit_in,
    input  logic               digit_valid,
    output logic [OTP_W-1:0]   otp_word,
    output logic [OTP_W-1:0]   user_word,
    output logic [2:0]         digit_cnt,
    output logic               unlock,
    output logic               locked,
    output logic               expired,
    output logic [1:0]         wrng_atmpt
);

    localparam int unsigned TMAX_A = (EXPIRE_CYCLES > UNLOCK_HOLD) ? EXPIRE_CYCLES : UNLOCK_HOLD;
    localparam int unsigned TMAX   = (TMAX_A > LOCK_CYCLES) ? TMAX_A : LOCK_CYCLES;
    localparam int unsigned TW     = cnt_width(TMAX);

    localparam logic [TW-1:0] EXP_LD  = TW'(EXPIRE_CYCLES - 1);
    localparam logic [TW-1:0] HOLD_LD = TW'(UNLOCK_HOLD - 1);
    localparam logic [TW-1:0] LOCK_LD = TW'(LOCK_CYCLES - 1);
    localparam logic [2:0]    DIG_LAST = 3'(DIGITS);
    localparam logic [1:0]    ATT_MAX  = 2'(MAX_ATTEMPTS);

    logic [2:0]       state_q, state_d;
    logic [OTP_W-1:0] otp_q, otp_d;
    logic [OTP_W-1:0] user_q, user_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [1:0]       att_q, att_d;

    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_zero;
    logic [2:0]    cnt_inc;
    logic [1:0]    att_inc;

    otp_cycle_timer #(
        .WIDTH (TW)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    assign cnt_inc = (cnt_q == DIG_LAST) ? cnt_q : cnt_q + 3'd1;
    assign att_inc = (att_q == 2'd3) ? att_q : att_q + 2'd1;

    always_comb begin
        state_d  = state_q;
        otp_d    = otp_q;
        user_d   = user_q;
        cnt_d    = cnt_q;
        att_d    = att_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            ST_IDLE, ST_EXPIRED, ST_ENTRY: begin
                if (gen_req) begin
                    // Capture (or recapture) wins over any digit in the same cycle.
                    state_d  = ST_ENTRY;
                    otp_d    = lfsr_word;
                    user_d   = '0;
                    cnt_d    = '0;
                    tmr_load = 1'b1;
                    tmr_val  = EXP_LD;
                end else if (state_q == ST_ENTRY) begin
                    if (digit_valid) begin
                        user_d = {user_q[OTP_W-DIGIT_W-1:0], digit_in};
                        cnt_d  = cnt_inc;
                    end
                    if (digit_valid && cnt_inc == DIG_LAST) begin
                        state_d = ST_CHECK;
                    end else if (tmr_zero) begin
                        state_d = ST_EXPIRED;
                        otp_d   = '0;
                    end
                end
            end
            ST_CHECK: begin
                if (user_q == otp_q) begin
                    state_d  = ST_GRANT;
                    att_d    = '0;
                    tmr_load = 1'b1;
                    tmr_val  = HOLD_LD;
                end else begin
                    user_d = '0;
                    cnt_d  = '0;
                    att_d  = att_inc;
                    if (att_inc == ATT_MAX) begin
                        state_d  = ST_LOCKOUT;
                        otp_d    = '0;
                        tmr_load = 1'b1;
                        tmr_val  = LOCK_LD;
                    end else begin
                        state_d = ST_ENTRY;
                    end
                end
            end
            ST_GRANT: begin
                if (tmr_zero) begin
                    state_d = ST_IDLE;
                    otp_d   = '0;
                end
            end
            ST_LOCKOUT: begin
                if (tmr_zero) begin
                    state_d = ST_IDLE;
                    att_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            otp_q   <= '0;
            user_q  <= '0;
            cnt_q   <= '0;
            att_q   <= '0;
        end else begin
            state_q <= state_d;
            otp_q   <= otp_d;
            user_q  <= user_d;
            cnt_q   <= cnt_d;
            att_q   <= att_d;
        end
    end

    assign otp_word   = otp_q;
    assign user_word  = user_q;
    assign digit_cnt  = cnt_q;
    assign wrng_atmpt = att_q;
    assign unlock     = (state_q == ST_GRANT);
    assign locked     = (state_q == ST_LOCKOUT);
    assign expired    = (state_q == ST_EXPIRED);

endmodule

// File: tb/tb_otp_session_ctrl.sv
// Scoreboard bench for otp_session_ctrl: directed session scenarios followed by random stimulus.
module tb_otp_session_ctrl;

    localparam int EXP  = 20;
    localparam int HOLD = 4;
    localparam int LOCK = 8;
    localparam int MAXA = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        gen_req;
    logic [15:0] lfsr_word;
    logic [3:0]  digit_in;
    logic        digit_valid;
    logic [15:0] otp_word;
    logic [15:0] user_word;
    logic [2:0]  digit_cnt;
    logic        unlock;
    logic        locked;
    logic        expired;
    logic [1:0]  wrng_atmpt;

    always #5 clk = ~clk;

    otp_session_ctrl #(
        .DIGITS        (4),
        .EXPIRE_CYCLES (EXP),
        .UNLOCK_HOLD   (HOLD),
        .LOCK_CYCLES   (LOCK),
        .MAX_ATTEMPTS  (MAXA)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .gen_req     (gen_req),
        .lfsr_word   (lfsr_word),
        .digit_in    (digit_in),
        .digit_valid (digit_valid),
        .otp_word    (otp_word),
        .user_word   (user_word),
        .digit_cnt   (digit_cnt),
        .unlock      (unlock),
        .locked      (locked),
        .expired     (expired),
        .wrng_atmpt  (wrng_atmpt)
    );

    typedef struct packed {
        logic [15:0] otp;
        logic [15:0] user;
        logic [2:0]  cnt;
        logic        unlock;
        logic        locked;
        logic        expired;
        logic [1:0]  att;
    } obs_t;

    obs_t exp_q[$];
    obs_t mon_exp, mon_act;
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference model: phase plus an absolute deadline cycle instead of a counter.
    typedef enum {Idle, Entry, Check, Grant, Expired, Lockout} phase_t;
    phase_t      ph;
    int          mcyc = 0;
    int          deadline = 0;
    logic [15:0] m_otp, m_user;
    int          m_cnt, m_att;

    function automatic obs_t model_obs();
        obs_t o;
        o.otp     = m_otp;
        o.user    = m_user;
        o.cnt     = 3'(m_cnt);
        o.unlock  = (ph == Grant);
        o.locked  = (ph == Lockout);
        o.expired = (ph == Expired);
        o.att     = 2'(m_att);
        return o;
    endfunction

    task automatic model_step(input bit rst, input bit gen, input logic [15:0] lfsr,
                              input bit dv, input logic [3:0] d);
        bit tdone;
        tdone = (mcyc >= deadline);
        if (rst) begin
            ph = Idle; m_otp = 0; m_user = 0; m_cnt = 0; m_att = 0;
        end else begin
            case (ph)
                Idle, Expired, Entry: begin
                    if (gen) begin
                        ph = Entry; m_otp = lfsr; m_user = 0; m_cnt = 0; deadline = mcyc + EXP;
                    end else if (ph == Entry) begin
                        if (dv) begin
                            m_user = {m_user[11:0], d};
                            m_cnt  = m_cnt + 1;
                        end
                        if (dv && m_cnt == 4) ph = Check;
                        else if (tdone) begin
                            ph = Expired; m_otp = 0;
                        end
                    end
                end
                Check: begin
                    if (m_user == m_otp) begin
                        ph = Grant; m_att = 0; deadline = mcyc + HOLD;
                    end else begin
                        m_user = 0; m_cnt = 0;
                        m_att = (m_att < 3) ? m_att + 1 : 3;
                        if (m_att == MAXA) begin
                            ph = Lockout; m_otp = 0; deadline = mcyc + LOCK;
                        end else ph = Entry;
                    end
                end
                Grant: if (tdone) begin ph = Idle; m_otp = 0; end
                Lockout: if (tdone) begin ph = Idle; m_att = 0; end
                default: ph = Idle;
            endcase
        end
        mcyc++;
    endtask

    // One clock of stimulus; the expectation is queued right after the edge it describes.
    task automatic cyc(input bit rst, input bit gen, input logic [15:0] lfsr,
                       input bit dv, input logic [3:0] d);
        obs_t e;
        reset = rst; gen_req = gen; lfsr_word = lfsr; digit_valid = dv; digit_in = d;
        model_step(rst, gen, lfsr, dv, d);
        e = model_obs();
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 16'h0, 0, 4'h0);
    endtask

    task automatic enter(input logic [15:0] w);
        logic [15:0] v;
        v = w;
        for (int i = 0; i < 4; i++) cyc(0, 0, 16'h0, 1, v[15-4*i -: 4]);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_act = {otp_word, user_word, digit_cnt, unlock, locked, expired, wrng_atmpt};
            n_vec++;
            if (mon_act !== mon_exp) begin
                n_bad++;
                $display("FAIL outputs @%0t: got otp=%h user=%h cnt=%0d unl=%b lck=%b exp=%b att=%0d, want otp=%h user=%h cnt=%0d unl=%b lck=%b exp=%b att=%0d",
                         $time, mon_act.otp, mon_act.user, mon_act.cnt, mon_act.unlock,
                         mon_act.locked, mon_act.expired, mon_act.att, mon_exp.otp,
                         mon_exp.user, mon_exp.cnt, mon_exp.unlock, mon_exp.locked,
                         mon_exp.expired, mon_exp.att);
            end
        end
    end

    initial begin
        bit          rst, gen, dv;
        logic [3:0]  d;
        logic [15:0] lw;
        reset = 1'b1; gen_req = 0; lfsr_word = 0; digit_valid = 0; digit_in = 0;
        @(posedge clk); #1;
        cyc(1, 0, 16'h0, 0, 4'h0);
        cyc(1, 1, 16'hFFFF, 1, 4'h5);
        if (otp_word !== 16'h0 || user_word !== 16'h0 || digit_cnt !== 3'd0 ||
            unlock !== 1'b0 || locked !== 1'b0 || expired !== 1'b0 || wrng_atmpt !== 2'd0) begin
            n_bad++;
            $display("FAIL reset state @%0t: otp=%h user=%h cnt=%0d unl=%b lck=%b exp=%b att=%0d",
                     $time, otp_word, user_word, digit_cnt, unlock, locked, expired, wrng_atmpt);
        end

        // Matching entry, unlock hold, single-use OTP.
        cyc(0, 1, 16'h3A7C, 0, 4'h0);
        enter(16'h3A7C);
        idle(8);

        // Three misses into lockout; gen_req during lockout ignored.
        cyc(0, 1, 16'h3A7C, 0, 4'h0);
        enter(16'h1234); idle(1);
        enter(16'h1234); idle(1);
        enter(16'h1234); idle(3);
        cyc(0, 1, 16'hBEEF, 1, 4'h1);
        idle(12);

        // Expiry after partial entry, then recapture clears expired.
        cyc(0, 1, 16'h5A5A, 0, 4'h0);
        cyc(0, 0, 16'h0, 1, 4'h5);
        cyc(0, 0, 16'h0, 1, 4'hA);
        idle(25);
        if (expired !== 1'b1 || otp_word !== 16'h0 || unlock !== 1'b0 || locked !== 1'b0) begin
            n_bad++;
            $display("FAIL expired wait @%0t: exp=%b otp=%h unl=%b lck=%b",
                     $time, expired, otp_word, unlock, locked);
        end
        cyc(0, 1, 16'h0F0F, 0, 4'h0);
        if (expired !== 1'b0 || otp_word !== 16'h0F0F) begin
            n_bad++;
            $display("FAIL recapture after expiry @%0t: exp=%b otp=%h", $time, expired, otp_word);
        end
        idle(1);
        cyc(0, 0, 16'h0, 1, 4'h0);

        // gen_req and digit_valid together: digit dropped, fresh capture.
        cyc(0, 1, 16'hC0DE, 1, 4'h9);
        cyc(0, 0, 16'h0, 1, 4'hC);
        cyc(0, 0, 16'h0, 1, 4'h0);
        cyc(0, 0, 16'h0, 1, 4'hD);

        // Reset mid-entry, then a digit while idle.
        cyc(1, 0, 16'h0, 1, 4'hE);
        cyc(0, 0, 16'h0, 1, 4'h7);

        // Final digit lands on the same cycle the expiry timer reaches zero.
        cyc(0, 1, 16'h1234, 0, 4'h0);
        idle(16);
        enter(16'h1234);
        idle(8);

        // Randomised sessions, biased toward correct digits so grants and lockouts both occur.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 999) < 3);
            gen = ($urandom_range(0, 99) < 4);
            dv  = ($urandom_range(0, 99) < 45);
            lw  = 16'($urandom());
            d   = 4'($urandom());
            if (ph == Entry && m_cnt < 4 && $urandom_range(0, 9) < 7) d = m_otp[15-4*m_cnt -: 4];
            cyc(rst, gen, lw, dv, d);
        end

        idle(1);
        @(negedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        if (n_bad != 0) $display("FAIL: %0d miscompares", n_bad);
        else $display("PASS");
        $finish;
    end

endmodule
